// File: rtl/sm3_pkg.sv
// Shared SM3 definitions.
//   SM3_DIGEST_W    : digest width in bits (256)
//   sm3_res_state_e : result serializer FSM states (IDLE, SEND)
//   SM3_ABC_DIGEST  : SM3 digest of the message "abc", used as a reference value
package sm3_pkg;

    localparam int SM3_DIGEST_W = 256;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sm3_res_state_e;

    localparam logic [SM3_DIGEST_W-1:0] SM3_ABC_DIGEST =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

endpackage

// File: rtl/sm3_res_serializer.sv
// sm3_res_serializer
// Captures the 256-bit SM3 digest on cmprss_otpt_vld and streams it out as
// WORD_NUM = 256/OTPT_DW words, most significant word first, over a
// valid/ready/last handshake. Digests arriving while a stream is draining
// are dropped and flagged in the sticky res_ovf bit.
//
// Optional feature macro: SM3_RES_CMP_EN
//   When defined, the captured digest is compared with res_exp and the
//   result is reported alongside word 0 of the stream.
//
// Ports:
//   clk              : clock, rising edge
//   rst_n            : synchronous active-low reset
//   cmprss_otpt_res  : digest from the core (valid with cmprss_otpt_vld)
//   cmprss_otpt_vld  : single-cycle digest strobe
//   res_otpt_d       : output word
//   res_otpt_vld     : output word valid
//   res_otpt_lst     : final word of a digest
//   res_otpt_rdy     : downstream ready
//   res_busy         : high while streaming
//   res_ovf          : sticky dropped-digest flag
//   res_ovf_clr      : clears res_ovf (a simultaneous new drop wins)
//   res_exp          : expected digest            (SM3_RES_CMP_EN only)
//   res_cmp_vld      : compare result strobe      (SM3_RES_CMP_EN only)
//   res_cmp_ok       : compare result, held       (SM3_RES_CMP_EN only)
module sm3_res_serializer
    import sm3_pkg::*;
#(
    parameter int OTPT_DW = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SM3_DIGEST_W-1:0] cmprss_otpt_res,
    input  logic                    cmprss_otpt_vld,
    output logic [OTPT_DW-1:0]      res_otpt_d,
    output logic                    res_otpt_vld,
    output logic                    res_otpt_lst,
    input  logic                    res_otpt_rdy,
    output logic                    res_busy,
    output logic                    res_ovf,
    input  logic                    res_ovf_clr
`ifdef SM3_RES_CMP_EN
    ,
    input  logic [SM3_DIGEST_W-1:0] res_exp,
    output logic                    res_cmp_vld,
    output logic                    res_cmp_ok
`endif
);

    localparam int WORD_NUM = SM3_DIGEST_W / OTPT_DW;
    localparam int CNT_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_NUM - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    sm3_res_state_e          state_q;
    logic [SM3_DIGEST_W-1:0] shreg_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
`ifdef SM3_RES_CMP_EN
    logic                    cmp_vld_q;
    logic                    cmp_ok_q;
`endif

    logic xfer;
    logic last_xfer;
    logic capture;
    logic drop;

    assign xfer      = (state_q == SEND) && res_otpt_rdy;
    assign last_xfer = xfer && (cnt_q == LAST_CNT);
    // A new digest is accepted when idle, or in the very cycle the final
    // word leaves, which keeps the stream gap-free for back-to-back digests.
    assign capture   = cmprss_otpt_vld && ((state_q == IDLE) || last_xfer);
    assign drop      = cmprss_otpt_vld && !capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef SM3_RES_CMP_EN
            cmp_vld_q <= 1'b0;
            cmp_ok_q  <= 1'b0;
`endif
        end else begin
            if (capture) begin
                state_q <= SEND;
                shreg_q <= cmprss_otpt_res;
                cnt_q   <= '0;
            end else if (xfer) begin
                // Once all words have shifted out the register is zero,
                // so the idle data output reads back as zero.
                shreg_q <= shreg_q << OTPT_DW;
                cnt_q   <= cnt_q + ONE_CNT;
                if (last_xfer) begin
                    state_q <= IDLE;
                end
            end

            // Sticky overflow; a drop in the same cycle as a clear wins.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (res_ovf_clr) begin
                ovf_q <= 1'b0;
            end

`ifdef SM3_RES_CMP_EN
            // Registered with the capture so the strobe lines up with word 0.
            cmp_vld_q <= capture;
            if (capture) begin
                cmp_ok_q <= (cmprss_otpt_res == res_exp);
            end
`endif
        end
    end

    assign res_otpt_vld = (state_q == SEND);
    assign res_otpt_d   = shreg_q[SM3_DIGEST_W-1 -: OTPT_DW];
    assign res_otpt_lst = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign res_busy     = (state_q == SEND);
    assign res_ovf      = ovf_q;
`ifdef SM3_RES_CMP_EN
    assign res_cmp_vld  = cmp_vld_q;
    assign res_cmp_ok   = cmp_ok_q;
`endif

endmodule

// File: tb/tb_sm3_res_serializer.sv
// Testbench for sm3_res_serializer (OTPT_DW = 32).
// Stimulus pushes expected {lst, word} pairs into a queue; a monitor on the
// falling clock edge pops and compares on every transfer, and also checks
// that a stalled word is held unchanged until it transfers.
module tb_sm3_res_serializer;
    import sm3_pkg::*;

    localparam int DW = 32;
    localparam logic [255:0] FIVE_A = {8{32'h5a5a5a5a}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] cmprss_otpt_res = '0;
    logic         cmprss_otpt_vld = 1'b0;
    logic [DW-1:0] res_otpt_d;
    logic         res_otpt_vld;
    logic         res_otpt_lst;
    logic         res_otpt_rdy = 1'b1;
    logic         res_busy;
    logic         res_ovf;
    logic         res_ovf_clr = 1'b0;
`ifdef SM3_RES_CMP_EN
    logic [255:0] res_exp = SM3_ABC_DIGEST;
    logic         res_cmp_vld;
    logic         res_cmp_ok;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_xfer = 0;
    logic [DW:0] exp_q[$];

    sm3_res_serializer #(.OTPT_DW(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmprss_otpt_res (cmprss_otpt_res),
        .cmprss_otpt_vld (cmprss_otpt_vld),
        .res_otpt_d      (res_otpt_d),
        .res_otpt_vld    (res_otpt_vld),
        .res_otpt_lst    (res_otpt_lst),
        .res_otpt_rdy    (res_otpt_rdy),
        .res_busy        (res_busy),
        .res_ovf         (res_ovf),
        .res_ovf_clr     (res_ovf_clr)
`ifdef SM3_RES_CMP_EN
        ,
        .res_exp         (res_exp),
        .res_cmp_vld     (res_cmp_vld),
        .res_cmp_ok      (res_cmp_ok)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the first nwords words of a digest; lst marks word 7.
    task automatic push_digest(input logic [255:0] v, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            exp_q.push_back({(i == 7), v[255 - 32*i -: 32]});
        end
    endtask

    // Strobe a digest for one cycle; returns in the cycle word 0 is valid.
    task automatic strobe(input logic [255:0] v);
        cmprss_otpt_res = v;
        cmprss_otpt_vld = 1'b1;
        tick();
        cmprss_otpt_vld = 1'b0;
    endtask

    // Wait (bounded) for the stream to end, then expect an empty scoreboard.
    task automatic drain(input string name);
        int cyc = 0;
        while (res_otpt_vld && cyc < 200) begin
            tick();
            cyc++;
        end
        check({name, "_drain_timeout"}, 64'(res_otpt_vld), 64'd0);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: scoreboard pop on each transfer plus stall-stability check.
    logic        held = 1'b0;
    logic [DW:0] held_val = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (held) begin
                check("stall_vld_kept", 64'(res_otpt_vld), 64'd1);
                check("stall_word_stable", 64'({res_otpt_lst, res_otpt_d}), 64'(held_val));
            end
            if (res_otpt_vld && res_otpt_rdy) begin
                n_xfer++;
                $display("xfer %0d: d=%h lst=%b", n_xfer, res_otpt_d, res_otpt_lst);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h lst=%b expected none", res_otpt_d, res_otpt_lst);
                end else begin
                    check("stream_word", 64'({res_otpt_lst, res_otpt_d}), 64'(exp_q.pop_front()));
                end
            end
            held     = res_otpt_vld && !res_otpt_rdy;
            held_val = {res_otpt_lst, res_otpt_d};
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        logic rdy_pat [4];
        int   cyc;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_d", 64'(res_otpt_d), 64'd0);
        check("rst_vld", 64'(res_otpt_vld), 64'd0);
        check("rst_lst", 64'(res_otpt_lst), 64'd0);
        check("rst_busy", 64'(res_busy), 64'd0);
        check("rst_ovf", 64'(res_ovf), 64'd0);
`ifdef SM3_RES_CMP_EN
        check("rst_cmp_vld", 64'(res_cmp_vld), 64'd0);
        check("rst_cmp_ok", 64'(res_cmp_ok), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Single digest, rdy held high: 8 consecutive words, one cycle latency
        res_otpt_rdy = 1'b1;
        push_digest(SM3_ABC_DIGEST, 8);
        strobe(SM3_ABC_DIGEST);
        check("single_w0_vld", 64'(res_otpt_vld), 64'd1);
        check("single_w0_busy", 64'(res_busy), 64'd1);
        check("single_w0_data", 64'(res_otpt_d), 64'h66c7f0f4);
`ifdef SM3_RES_CMP_EN
        check("cmp_vld_w0", 64'(res_cmp_vld), 64'd1);
        check("cmp_ok_abc", 64'(res_cmp_ok), 64'd1);
`endif
        repeat (7) tick();
        check("single_w7_lst", 64'(res_otpt_lst), 64'd1);
        check("single_w7_data", 64'(res_otpt_d), 64'h8f4ba8e0);
`ifdef SM3_RES_CMP_EN
        check("cmp_vld_pulse_only", 64'(res_cmp_vld), 64'd0);
        check("cmp_ok_held", 64'(res_cmp_ok), 64'd1);
`endif
        tick();
        check("single_vld_after", 64'(res_otpt_vld), 64'd0);
        check("single_busy_after", 64'(res_busy), 64'd0);
        check("single_sb_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure: rdy 1,0,0,1 repeating
        push_digest(SM3_ABC_DIGEST, 8);
        strobe(SM3_ABC_DIGEST);
        cyc = 0;
        while (res_otpt_vld && cyc < 100) begin
            res_otpt_rdy = rdy_pat[cyc % 4];
            tick();
            cyc++;
        end
        res_otpt_rdy = 1'b1;
        check("bp_timeout", 64'(res_otpt_vld), 64'd0);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Overflow: second strobe at word 3 is dropped
        push_digest(SM3_ABC_DIGEST, 8);
        strobe(SM3_ABC_DIGEST);
        repeat (3) tick();
        strobe(FIVE_A);
        check("ovf_set", 64'(res_ovf), 64'd1);
        drain("ovf");
        check("ovf_sticky", 64'(res_ovf), 64'd1);
        res_ovf_clr = 1'b1;
        tick();
        res_ovf_clr = 1'b0;
        check("ovf_cleared", 64'(res_ovf), 64'd0);

        // Clear and overflow in the same cycle: set wins
        push_digest(SM3_ABC_DIGEST, 8);
        strobe(SM3_ABC_DIGEST);
        tick();
        res_ovf_clr = 1'b1;
        strobe(FIVE_A);
        res_ovf_clr = 1'b0;
        check("ovf_set_wins", 64'(res_ovf), 64'd1);
        drain("ovf2");

        // Back-to-back: new strobe coincides with lst transfer
        push_digest(SM3_ABC_DIGEST, 8);
        push_digest(FIVE_A, 8);
        strobe(SM3_ABC_DIGEST);
        repeat (7) tick();
        check("b2b_lst", 64'(res_otpt_lst), 64'd1);
        strobe(FIVE_A);
        check("b2b_vld_kept", 64'(res_otpt_vld), 64'd1);
        check("b2b_w0_data", 64'(res_otpt_d), 64'h5a5a5a5a);
        check("b2b_w0_lst", 64'(res_otpt_lst), 64'd0);
        repeat (8) tick();
        check("b2b_vld_after", 64'(res_otpt_vld), 64'd0);
        check("b2b_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset at word 4: only words 0..3 are ever transferred
        push_digest(SM3_ABC_DIGEST, 4);
        strobe(SM3_ABC_DIGEST);
        repeat (4) tick();
        check("rst4_data", 64'(res_otpt_d), 64'h4167c487);
        rst_n = 1'b0;
        res_otpt_rdy = 1'b0;
        tick();
        check("rst4_d", 64'(res_otpt_d), 64'd0);
        check("rst4_vld", 64'(res_otpt_vld), 64'd0);
        check("rst4_lst", 64'(res_otpt_lst), 64'd0);
        check("rst4_busy", 64'(res_busy), 64'd0);
        check("rst4_ovf", 64'(res_ovf), 64'd0);
        rst_n = 1'b1;
        res_otpt_rdy = 1'b1;
        check("rst4_sb_empty", 64'(exp_q.size()), 64'd0);
        tick();
        push_digest(SM3_ABC_DIGEST, 8);
        strobe(SM3_ABC_DIGEST);
        check("post_rst_w0", 64'(res_otpt_d), 64'h66c7f0f4);
        drain("post_rst");

`ifdef SM3_RES_CMP_EN
        // Compare mismatch: bit 0 flipped
        push_digest(SM3_ABC_DIGEST ^ 256'h1, 8);
        strobe(SM3_ABC_DIGEST ^ 256'h1);
        check("cmp_vld_bad", 64'(res_cmp_vld), 64'd1);
        check("cmp_ok_bad", 64'(res_cmp_ok), 64'd0);
        drain("cmp_bad");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
